// File: rtl/grant_arbiter_8.sv
// Round-robin arbiter over N_REQ requesters with registered one-hot and
// binary grant, owner hold limit and a preemption pulse.
module grant_arbiter_8 #(
    parameter int N_REQ    = 8,
    parameter int IDX_BIT  = $clog2(N_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    output logic [IDX_BIT-1:0] gnt_idx,
    output logic               gnt_valid,
    output logic               preempt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_n;

    logic [IDX_BIT-1:0] ptr, ptr_n;
    logic [IDX_BIT-1:0] owner, owner_n;
    logic [7:0]         hold_cnt, hold_n;
    logic               pre_n;

    logic [N_REQ-1:0]   others;
    logic [N_REQ-1:0]   cand;
    logic               win_any;
    logic [IDX_BIT-1:0] win_idx;

    // First set bit scanning upward from p with wrap-around; MSB = found.
    function automatic logic [IDX_BIT:0] rr_pick(
        input logic [N_REQ-1:0]   v,
        input logic [IDX_BIT-1:0] p
    );
        logic [IDX_BIT-1:0] j;
        rr_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = p + IDX_BIT'(k);
            if (v[j]) rr_pick = {1'b1, j};
        end
    endfunction

    always_comb begin
        others        = req;
        others[owner] = 1'b0;
    end

    assign cand = (state == IDLE) ? req : others;
    assign {win_any, win_idx} = rr_pick(cand, ptr);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold_cnt;
        pre_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_any) begin
                    state_n = BUSY;
                    owner_n = win_idx;
                    ptr_n   = win_idx + IDX_BIT'(1);
                    hold_n  = 8'd1;
                end
            end
            BUSY: begin
                if (!req[owner]) begin
                    if (win_any) begin
                        owner_n = win_idx;
                        ptr_n   = win_idx + IDX_BIT'(1);
                        hold_n  = 8'd1;
                    end else begin
                        state_n = IDLE;
                        hold_n  = 8'd0;
                    end
                end else if (hold_cnt < 8'(MAX_HOLD)) begin
                    hold_n = hold_cnt + 8'd1;
                end else if (win_any) begin
                    owner_n = win_idx;
                    ptr_n   = win_idx + IDX_BIT'(1);
                    hold_n  = 8'd1;
                    pre_n   = 1'b1;
                end else begin
                    // Nobody else waiting: restart the hold window in place.
                    hold_n = 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            preempt  <= pre_n;
        end
    end

    always_comb begin
        gnt = '0;
        if (state == BUSY) gnt[owner] = 1'b1;
    end

    assign gnt_idx   = (state == BUSY) ? owner : '0;
    assign gnt_valid = (state == BUSY);

endmodule

// File: tb/tb_grant_arbiter_8.sv
// Directed and randomized checks of grant_arbiter_8 against a
// rule-level reference model.
module tb_grant_arbiter_8;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_checks = 0;
    int n_err    = 0;

    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    logic [7:0] prev_r;
    logic [7:0] r;

    grant_arbiter_8 #(
        .N_REQ   (8),
        .IDX_BIT (3),
        .MAX_HOLD(MH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] v, input int start);
        for (int k = 0; k < 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_busy  = 1'b1;
        m_owner = w;
        m_ptr   = (w + 1) % 8;
        m_hold  = 1;
    endtask

    task automatic model(input logic [7:0] rq, input logic rv);
        logic [7:0] oth;
        m_pre = 1'b0;
        if (!rv) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (!m_busy) begin
            if (rq != 0) take(pick(rq, m_ptr));
        end else begin
            oth = rq;
            oth[m_owner] = 1'b0;
            if (!rq[m_owner]) begin
                if (oth != 0) take(pick(oth, m_ptr));
                else m_busy = 1'b0;
            end else if (m_hold < MH) begin
                m_hold++;
            end else if (oth != 0) begin
                take(pick(oth, m_ptr));
                m_pre = 1'b1;
            end else begin
                m_hold = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] rq, input logic rv);
        logic [7:0] eg;
        req   = rq;
        rst_n = rv;
        @(posedge clk);
        model(rq, rv);
        #1;
        eg = m_busy ? 8'(1 << m_owner) : 8'h00;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_idx", 32'(gnt_idx), m_busy ? 32'(m_owner) : 32'd0);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        chk("preempt", 32'(preempt), 32'(m_pre));
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        req   = 8'h00;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_pre = 0;

        // reset with all requests high
        for (int i = 0; i < 2; i++) begin
            cyc(8'hFF, 1'b0);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_valid", 32'(gnt_valid), 32'h0);
            chk("rst_pre", 32'(preempt), 32'h0);
        end
        cyc(8'hFF, 1'b1);
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_idx", 32'(gnt_idx), 32'd0);
        cyc(8'h00, 1'b1);
        chk("idle_gnt", 32'(gnt), 32'h0);

        // single requester
        for (int i = 0; i < 3; i++) begin
            cyc(8'h20, 1'b1);
            chk("single_gnt", 32'(gnt), 32'h20);
            chk("single_idx", 32'(gnt_idx), 32'd5);
        end
        cyc(8'h00, 1'b1);
        chk("single_rel", 32'(gnt), 32'h0);
        cyc(8'h01, 1'b1);
        chk("next_idx", 32'(gnt_idx), 32'd0);
        chk("next_valid", 32'(gnt_valid), 32'd1);
        cyc(8'h00, 1'b1);

        // round robin with wrap
        cyc(8'hFF, 1'b0);
        cyc(8'hFF, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk("rr_idx", 32'(gnt_idx), 32'(i % 8));
            chk("rr_valid", 32'(gnt_valid), 32'd1);
            cyc(8'hFF, 1'b1);
            chk("rr_keep", 32'(gnt_idx), 32'(i % 8));
            cyc(8'hFF & ~8'(1 << (i % 8)), 1'b1);
        end

        // hold limit
        cyc(8'h00, 1'b0);
        cyc(8'h04, 1'b1);
        chk("hold_idx0", 32'(gnt_idx), 32'd2);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h44, 1'b1);
            chk("hold_idx", 32'(gnt_idx), 32'd2);
            chk("hold_pre", 32'(preempt), 32'd0);
        end
        cyc(8'h44, 1'b1);
        chk("preempt_idx", 32'(gnt_idx), 32'd6);
        chk("preempt_pulse", 32'(preempt), 32'd1);
        cyc(8'h44, 1'b1);
        chk("preempt_end", 32'(preempt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(8'h04, 1'b1);
            chk("alone_idx", 32'(gnt_idx), 32'd2);
            chk("alone_pre", 32'(preempt), 32'd0);
        end

        // drop coincident with hold limit
        cyc(8'h00, 1'b0);
        cyc(8'h04, 1'b1);
        for (int i = 0; i < 3; i++) cyc(8'h44, 1'b1);
        cyc(8'h40, 1'b1);
        chk("drop_lim_idx", 32'(gnt_idx), 32'd6);
        chk("drop_lim_pre", 32'(preempt), 32'd0);

        // reset mid-grant
        cyc(8'h00, 1'b0);
        cyc(8'h08, 1'b1);
        chk("mid_gnt", 32'(gnt), 32'h08);
        cyc(8'h18, 1'b0);
        chk("mid_rst", 32'(gnt), 32'h0);
        cyc(8'h18, 1'b1);
        chk("mid_after", 32'(gnt_idx), 32'd3);

        // randomized traffic
        prev_r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            r = prev_r;
            if ($urandom_range(0, 9) < 3)
                r = 8'($urandom) & 8'($urandom);
            prev_r = r;
            cyc(r, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
